lsu_mem_access: RTL
===================

LSU_MEM_ACCESS -- requirements
Module: lsu_mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles spent in REQ+WAIT_R before a bus error.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ex_valid  input  1  EX/MEM stage holds a valid instruction.
REQ-005 mem_read / mem_write  input  1 each  load / store request.
REQ-006 ls_type  input  3  access type, shared LB/LH/LW/LBU/LHU codes; stores use LB=SB, LH=SH, LW=SW.
REQ-007 addr  input  32  byte address.
REQ-008 store_data  input  32  unaligned store operand, LSBs valid.
REQ-009 dmem_req  output  1  request to data memory.
REQ-010 dmem_we / dmem_be / dmem_addr / dmem_wdata  output  1/4/32/32  write enable, byte lanes, word address ({addr[31:2],2'b00}), lane-replicated write data.
REQ-011 dmem_gnt / dmem_rvalid / dmem_rdata  input  1/1/32  grant, read-data valid, read word.
REQ-012 stall  output  1  freeze upstream pipeline.
REQ-013 mem_read_data  output  32  read word shifted right by 8*addr[1:0]; feeds the load-format stage.
REQ-014 rd_valid  output  1  mem_read_data valid (one-cycle pulse).
REQ-015 misalign_exc / bus_err  output  1 each  one-cycle exception pulses; exc_addr  output  32  faulting address.

Function
REQ-016 FSM states IDLE, REQ, WAIT_R, DONE; registered state.
REQ-017 Access = ex_valid & (mem_read | mem_write); both set -> treated as load.
REQ-018 Misaligned = LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
REQ-019 IDLE + aligned access -> REQ; IDLE + misaligned -> stay IDLE, misalign_exc=1 and exc_addr=addr next cycle, no dmem_req, no stall.
REQ-020 In REQ, dmem_req=1 with addr/we/be/wdata held stable (registered at entry) until dmem_gnt.
REQ-021 REQ + gnt: store -> DONE; load -> WAIT_R. gnt in same cycle as rvalid is not accepted; rvalid counted only in WAIT_R.
REQ-022 WAIT_R + rvalid -> DONE, mem_read_data <= dmem_rdata >> (8*addr[1:0]).
REQ-023 DONE: stall=0, rd_valid=1 for loads only; unconditionally -> IDLE next cycle.
REQ-024 stall = access & ~misaligned & (state != DONE), combinational.
REQ-025 dmem_be: byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111; same for loads and stores.
REQ-026 dmem_wdata: byte {4{sd[7:0]}}, half {2{sd[15:0]}}, word sd.
REQ-027 Timeout counter clears on entry to REQ; when it reaches TIMEOUT_CYCLES in REQ/WAIT_R -> DONE, bus_err=1, exc_addr=addr, rd_valid=0.
REQ-028 dmem_rvalid outside WAIT_R is ignored.
REQ-029 mem_read_data holds its value outside DONE.

Reset
REQ-030 rst_n low -> state IDLE, counter 0, all outputs 0 (mem_read_data, exc_addr 32'h0) immediately, asynchronously.
REQ-031 Reset mid-transaction drops dmem_req at once; a later rvalid for the aborted load is ignored.

Structure
REQ-032 ls_type codes and FSM state encodings live in the shared defines file; no local redefinition.
REQ-033 One sub-module, lsu_lane_align: combinational be/wdata generation and read-data shift.

Verification
REQ-034 LW addr 0x100, gnt cycle 1, rvalid cycle 2 with rdata 0xDEADBEEF -> rd_valid in DONE (3rd cycle after accept), mem_read_data 0xDEADBEEF, stall high exactly 3 cycles.
REQ-035 LB addr 0x103, rdata 0x80112233 -> mem_read_data 0x00000080, dmem_be 4'b1000.
REQ-036 SH addr 0x202, store_data 0x0000ABCD, gnt delayed 4 cycles -> dmem_be 4'b1100, dmem_wdata 0xABCDABCD stable all 4 cycles, no rd_valid.
REQ-037 LW addr 0x101 -> misalign_exc pulse, exc_addr 0x101, dmem_req never high, stall 0.
REQ-038 TIMEOUT_CYCLES=8, no gnt -> bus_err after 8 cycles, FSM back in IDLE.
REQ-039 rst_n low in WAIT_R, then rvalid -> dmem_req 0 immediately, no rd_valid.

Source files
------------

// File: rtl/lsu_mem_access_pkg.sv
// Shared LSU definitions: access-type codes, FSM states,
// and access-size helpers for the memory-access stage.
package lsu_mem_access_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_R,
    ST_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } acc_size_e;

  // Unknown codes fall back to a full word access.
  function automatic acc_size_e acc_size(
    input logic [2:0] t
  );
    acc_size_e s;
    s = SZ_W;
    unique case (1'b1)
      (t == LS_B) || (t == LS_BU): s = SZ_B;
      (t == LS_H) || (t == LS_HU): s = SZ_H;
      default:                     s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic is_misaligned(
    input logic [2:0] t,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    case (acc_size(t))
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / replicated
// write data, and right-alignment of the returned read word.
module lsu_lane_align
  import lsu_mem_access_pkg::*;
(
  input  logic [2:0]  ls_type,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_shift
);

  // Lane mask and replicated data by access size.
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (acc_size(ls_type))
      SZ_B: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      SZ_H: begin
        be    = 4'b0011 << off;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  assign rdata_shift = rdata >> {rd_off, 3'b000};

endmodule

// File: rtl/lsu_mem_access.sv
// Memory-access stage: drives the data-memory handshake,
// stalls upstream, and reports misalign / bus errors.
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  ls_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] mem_read_data,
  output logic        rd_valid,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic [31:0] exc_addr
);

  localparam int unsigned CW =
    $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e    state;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic          is_load_q;

  logic          access;
  logic          misaligned;
  logic          timeout;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   rdata_sh;

  assign access     = ex_valid & (mem_read | mem_write);
  assign misaligned = is_misaligned(ls_type, addr[1:0]);
  assign stall      = access & ~misaligned &
                      (state != ST_DONE);
  assign timeout    = (cnt >= CNT_LAST);

  lsu_lane_align u_align (
    .ls_type     (ls_type),
    .off         (addr[1:0]),
    .store_data  (store_data),
    .rd_off      (addr_q[1:0]),
    .rdata       (dmem_rdata),
    .be          (be_c),
    .wdata       (wdata_c),
    .rdata_shift (rdata_sh)
  );

  // Access FSM with registered bus and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      is_load_q     <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_be       <= 4'b0000;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      mem_read_data <= '0;
      rd_valid      <= 1'b0;
      misalign_exc  <= 1'b0;
      bus_err       <= 1'b0;
      exc_addr      <= '0;
    end else begin
      rd_valid     <= 1'b0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (access && misaligned) begin
            misalign_exc <= 1'b1;
            exc_addr     <= addr;
          end else if (access) begin
            state      <= ST_REQ;
            cnt        <= '0;
            addr_q     <= addr;
            is_load_q  <= mem_read;
            dmem_req   <= 1'b1;
            dmem_we    <= ~mem_read;
            dmem_be    <= be_c;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_wdata <= wdata_c;
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            cnt      <= cnt + 1'b1;
            state    <= is_load_q ? ST_WAIT_R
                                  : ST_DONE;
          end else if (timeout) begin
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
            exc_addr <= addr_q;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_R: begin
          if (dmem_rvalid) begin
            mem_read_data <= rdata_sh;
            rd_valid      <= 1'b1;
            state         <= ST_DONE;
          end else if (timeout) begin
            bus_err  <= 1'b1;
            exc_addr <= addr_q;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
